// File: rtl/alarm_timer.sv
// Countdown alarm: loads a 0..31 second count on start_timer and decrements it once per
// CLK_HZ clock cycles. It pulses expired when the count reaches zero or when a zero count is started.
module alarm_timer #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start_timer,
   input  logic [4:0] value,
   output logic       expired,
   output logic       busy,
   output logic [4:0] remaining,
   output logic       one_hz_enable
);

   localparam int                 DIV_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [DIV_W-1:0]   DIV_MAX = DIV_W'(CLK_HZ - 1);

   typedef enum logic {
      IDLE,
      COUNTING
   } state_t;

   state_t           state, state_next;
   logic [DIV_W-1:0] divider, divider_next;
   logic [4:0]       remaining_next;
   logic             expired_next;
   logic             wrap;

   // The divider is held at zero in IDLE, so a wrap can only happen while counting.
   assign wrap          = (state == COUNTING) && (divider == DIV_MAX);
   assign one_hz_enable = wrap;
   assign busy          = (state == COUNTING);

   always_comb begin
      state_next     = state;
      divider_next   = divider;
      remaining_next = remaining;
      expired_next   = 1'b0;

      // A start request wins over a coincident wrap, so an aborted count never expires.
      if (start_timer) begin
         remaining_next = value;
         divider_next   = '0;
         if (value == 5'd0) begin
            state_next   = IDLE;
            expired_next = 1'b1;
         end else begin
            state_next   = COUNTING;
         end
      end else if (state == COUNTING) begin
         if (wrap) begin
            divider_next = '0;
            if (remaining > 5'd1) begin
               remaining_next = remaining - 5'd1;
            end else begin
               remaining_next = 5'd0;
               state_next     = IDLE;
               expired_next   = (remaining == 5'd1);
            end
         end else begin
            divider_next = divider + DIV_W'(1);
         end
      end else begin
         divider_next = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; the reset branch is synchronous and overrides any start or wrap.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         divider   <= '0;
         remaining <= 5'd0;
         expired   <= 1'b0;
      end else begin
         state     <= state_next;
         divider   <= divider_next;
         remaining <= remaining_next;
         expired   <= expired_next;
      end
   end

endmodule

// File: tb/tb_alarm_timer.sv
// Directed self-checking bench for alarm_timer with CLK_HZ=4; outputs are sampled
// 1 ns after each rising edge and expected values are hand-computed per step.
module tb_alarm_timer;

   logic       clock = 1'b0;
   logic       reset;
   logic       start_timer;
   logic [4:0] value;
   logic       expired;
   logic       busy;
   logic [4:0] remaining;
   logic       one_hz_enable;

   int checks = 0;
   int errors = 0;

   alarm_timer #(.CLK_HZ(4)) dut (
      .clock         (clock),
      .reset         (reset),
      .start_timer   (start_timer),
      .value         (value),
      .expired       (expired),
      .busy          (busy),
      .remaining     (remaining),
      .one_hz_enable (one_hz_enable)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Runs n edges and counts how many sampled cycles showed each output high.
   task automatic watch(input int n, output int exp_cnt, output int busy_cnt, output int tick_cnt);
      exp_cnt  = 0;
      busy_cnt = 0;
      tick_cnt = 0;
      repeat (n) begin
         tick();
         exp_cnt  += int'(expired);
         busy_cnt += int'(busy);
         tick_cnt += int'(one_hz_enable);
      end
   endtask

   task automatic start(input logic [4:0] v);
      start_timer = 1'b1;
      value       = v;
      tick();
      start_timer = 1'b0;
   endtask

   int e_cnt, b_cnt, t_cnt;

   initial begin
      reset       = 1'b1;
      start_timer = 1'b0;
      value       = 5'd0;
      tick(2);
      check("rst_busy", busy, 0);
      check("rst_remaining", remaining, 0);
      check("rst_expired", expired, 0);
      check("rst_tick", one_hz_enable, 0);
      reset = 1'b0;
      tick();

      // value=3 started at edge 0: steps at edges 4, 8, 12
      start(5'd3);
      check("v3_e0_busy", busy, 1);
      check("v3_e0_rem", remaining, 3);
      check("v3_e0_tick", one_hz_enable, 0);
      tick(3);
      check("v3_e3_tick", one_hz_enable, 1);
      check("v3_e3_rem", remaining, 3);
      tick();
      check("v3_e4_rem", remaining, 2);
      check("v3_e4_tick", one_hz_enable, 0);
      tick(4);
      check("v3_e8_rem", remaining, 1);
      tick(3);
      check("v3_e11_exp", expired, 0);
      check("v3_e11_busy", busy, 1);
      tick();
      check("v3_e12_exp", expired, 1);
      check("v3_e12_rem", remaining, 0);
      check("v3_e12_busy", busy, 0);
      tick();
      check("v3_e13_exp", expired, 0);
      watch(6, e_cnt, b_cnt, t_cnt);
      check("v3_idle_tick", t_cnt, 0);
      check("v3_idle_rem", remaining, 0);

      // value=0: immediate expiry, never busy
      start(5'd0);
      check("v0_exp", expired, 1);
      check("v0_busy", busy, 0);
      watch(8, e_cnt, b_cnt, t_cnt);
      check("v0_no_busy", b_cnt, 0);
      check("v0_no_tick", t_cnt, 0);
      check("v0_no_reexp", e_cnt, 0);

      // value=0 while counting forces IDLE and clears remaining
      start(5'd7);
      tick(2);
      start(5'd0);
      check("v0abort_exp", expired, 1);
      check("v0abort_busy", busy, 0);
      check("v0abort_rem", remaining, 0);
      tick();

      // value=5 restarted with value=2 at edge 6: expiry at edge 14 only
      start(5'd5);
      tick(4);
      check("rs_e4_rem", remaining, 4);
      tick();
      start(5'd2);
      check("rs_e6_rem", remaining, 2);
      tick(7);
      check("rs_e13_exp", expired, 0);
      check("rs_e13_rem", remaining, 1);
      tick();
      check("rs_e14_exp", expired, 1);
      watch(12, e_cnt, b_cnt, t_cnt);
      check("rs_no_late_exp", e_cnt, 0);

      // value=4 with reset asserted at edge 9
      start(5'd4);
      tick(8);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst9_busy", busy, 0);
      check("rst9_rem", remaining, 0);
      check("rst9_exp", expired, 0);
      check("rst9_tick", one_hz_enable, 0);
      watch(40, e_cnt, b_cnt, t_cnt);
      check("rst9_no_exp", e_cnt, 0);
      check("rst9_no_busy", b_cnt, 0);

      // reset overrides a coincident start
      reset       = 1'b1;
      start_timer = 1'b1;
      value       = 5'd9;
      tick();
      reset       = 1'b0;
      start_timer = 1'b0;
      check("rst_start_busy", busy, 0);
      check("rst_start_rem", remaining, 0);

      // value changes during counting are ignored
      start(5'd2);
      value = 5'd31;
      tick(7);
      check("vchg_e7_exp", expired, 0);
      check("vchg_e7_rem", remaining, 1);
      tick();
      check("vchg_e8_exp", expired, 1);
      tick();

      // restart coincident with a wrap at edge 4
      start(5'd3);
      tick(3);
      check("cw_e3_tick", one_hz_enable, 1);
      start(5'd1);
      check("cw_e4_rem", remaining, 1);
      check("cw_e4_busy", busy, 1);
      check("cw_e4_tick", one_hz_enable, 0);
      check("cw_e4_exp", expired, 0);
      tick(3);
      check("cw_e7_exp", expired, 0);
      tick();
      check("cw_e8_exp", expired, 1);
      check("cw_e8_rem", remaining, 0);
      tick();

      // start held high reloads every cycle; count runs only after release
      start_timer = 1'b1;
      value       = 5'd2;
      watch(10, e_cnt, b_cnt, t_cnt);
      start_timer = 1'b0;
      check("hold_rem", remaining, 2);
      check("hold_no_tick", t_cnt, 0);
      check("hold_no_exp", e_cnt, 0);
      tick(7);
      check("hold_e7_exp", expired, 0);
      tick();
      check("hold_e8_exp", expired, 1);
      tick();
      check("hold_after_exp", expired, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alarm_timer.md
ALARM_TIMER -- requirements
Module: alarm_timer

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, meaning clock cycles per one-second tick; values >= 2 are legal.
REQ-002 The block SHALL have port clock  in  1  system clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port start_timer  in  1  load value and begin countdown; level sampled each edge.
REQ-005 The block SHALL have port value  in  5  countdown length in seconds (0..31), supplied by the time-parameter stage.
REQ-006 The block SHALL have port expired  out  1  registered one-cycle pulse when the countdown reaches zero.
REQ-007 The block SHALL have port busy  out  1  high while in COUNTING.
REQ-008 The block SHALL have port remaining  out  5  current remaining seconds.
REQ-009 The block SHALL have port one_hz_enable  out  1  one-cycle tick pulse, only while COUNTING.

Function
REQ-010 The FSM SHALL have states IDLE and COUNTING; busy SHALL be 1 exactly in COUNTING.
REQ-011 In any state, start_timer=1 at edge k with value=N>0 SHALL load remaining=N, clear the divider to 0, and enter COUNTING at edge k.
REQ-012 start_timer=1 with value=0 SHALL keep or force IDLE, set remaining=0, and assert expired for the cycle after edge k.
REQ-013 value SHALL be sampled only on start_timer; changes to value during COUNTING SHALL have no effect.
REQ-014 In COUNTING, the divider SHALL count 0..CLK_HZ-1 and wrap to 0; one_hz_enable SHALL be 1 for the cycle in which the divider equals CLK_HZ-1.
REQ-015 When the divider wraps in COUNTING, remaining SHALL decrement by 1; no underflow below 0 is permitted.
REQ-016 A wrap that takes remaining from 1 to 0 SHALL also return the FSM to IDLE and set expired to 1 for exactly one cycle.
REQ-017 For value=N>0 started at edge k, expired SHALL rise at edge k+N*CLK_HZ.
REQ-018 In IDLE, the divider SHALL be held at 0, one_hz_enable SHALL be 0, and remaining SHALL hold its last value.
REQ-019 start_timer during COUNTING SHALL restart the count from the new value; it SHALL take priority over a coincident divider wrap, and expired SHALL NOT fire for the aborted count.
REQ-020 start_timer held high SHALL reload every cycle, so the count never progresses until it is released.
REQ-021 expired SHALL be 0 on every cycle other than the cycles named in REQ-012 and REQ-016.

Reset
REQ-022 reset=1 at an edge SHALL force IDLE, divider=0, remaining=0, expired=0, busy=0, and one_hz_enable=0.
REQ-023 reset SHALL override start_timer and any pending wrap or expiry in the same cycle.
REQ-024 After a reset mid-count, no expired pulse SHALL be produced for the aborted count.

Verification (CLK_HZ=4)
REQ-025 Start with value=3 at edge 0 -> busy=1; remaining steps 3,2,1,0 at edges 4,8,12; expired high exactly one cycle from edge 12; busy=0 after edge 12.
REQ-026 Start with value=0 -> expired high one cycle after the start edge; busy never 1; one_hz_enable never 1.
REQ-027 Start with value=5, then restart with value=2 at edge 6 -> no expiry near edge 20; expired rises at edge 14.
REQ-028 Start with value=4, assert reset at edge 9 -> all outputs 0 from edge 9; no expired pulse within 40 cycles.
REQ-029 Start with value=2, change value to 31 at edge 1 -> expired still rises at edge 8.
REQ-030 Restart coincident with a wrap (start at edge 4 of a value=3 count, new value=1) -> remaining=1 at edge 4, no decrement at edge 4, expired rises at edge 8.
